bullet_slot_scheduler: RTL
==========================

Name: bullet_slot_scheduler

Overview:
- Allocates and retires the player's bullet slots. Drives the per-slot enable lines that feed the bullet sprite/motion datapath, replacing per-bullet enable PIOs.
- Turns fire-button edges into launches into the lowest free slot, subject to a cooldown. Retires each bullet on hit, off-screen or lifetime expiry.
- Presents a small Avalon-MM slave so Nios software can read slot state and tune lifetime.

Parameters:
- NUM_SLOTS, 4, number of bullet slots (1..8).
- LIFETIME_FRAMES, 60, reset value of lifetime reload, in frames (1..255).
- COOLDOWN_FRAMES, 8, minimum frames between launches (0..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- fire  in  1  fire button level, already synchronised to clk.
- frame_tick  in  1  one-cycle pulse per video frame (vsync edge).
- hit  in  NUM_SLOTS  per-slot collision pulse; retires that slot.
- offscreen  in  NUM_SLOTS  per-slot level; retires that slot while high.
- slot_en  out  NUM_SLOTS  per-slot bullet enable.
- launch  out  1  one-cycle pulse when a slot is allocated.
- launch_slot  out  3  index of the slot allocated; valid with launch, held otherwise.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon select.
- write_n  in  1  Avalon write strobe, active low.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, combinational from address, zero-extended.

Behaviour:
- Reset values: slot_en=0, launch=0, launch_slot=0, cooldown counter=0, all lifetime counters=0, lifetime_reload=LIFETIME_FRAMES, ctrl=1 (enable=1, autofire=0), launch_count=0, fire_q=0.
- Fire request:
  - autofire=0: request = fire & ~fire_q (rising edge).
  - autofire=1: request = fire level.
- Launch condition, evaluated every cycle: request & enable & cooldown==0 & any free slot. Free means slot_en bit is 0 in the current registered state.
- On launch:
  - The next edge sets slot_en[k] (k = lowest-index free slot), loads lifetime[k]=lifetime_reload and sets cooldown=COOLDOWN_FRAMES.
  - launch pulses for one cycle and launch_slot=k. Latency is one clock from the fire edge.
- Request with no free slot, cooldown nonzero, or enable=0: dropped, never queued.
- On frame_tick:
  - cooldown decrements if nonzero.
  - Each enabled slot's lifetime decrements. A slot whose lifetime is 1 is retired on that tick.
- Retire slot k (clear slot_en[k], lifetime[k]=0) on any of: hit[k]; offscreen[k]; lifetime expiry; software W1C.
- Simultaneous events:
  - Retire and launch in the same cycle: the retired slot is not a candidate. It becomes free the following cycle.
  - Launch and frame_tick in the same cycle: the new slot loads the full reload value and is not decremented that cycle. Cooldown loads COOLDOWN_FRAMES and does not decrement that cycle.
  - Retire causes on an unenabled slot: ignored.
- Writing enable=0 retires all slots at the next edge and blocks launches.
- Asserting reset mid-flight clears everything immediately (asynchronous). No launch pulse is emitted as reset releases.
- Register map (writes require chipselect & ~write_n):
  - addr0 SLOTS: read = slot_en. Write = W1C of slots by writedata[NUM_SLOTS-1:0].
  - addr1 LIFETIME: bits[7:0] RW reload. Writing 0 stores 1. Affects only later launches.
  - addr2 CTRL: bit0 enable, bit1 autofire, RW.
  - addr3 COUNT: bits[15:0] launches, wraps at 0xFFFF->0. Any write clears it. A launch in the same cycle as a write gives COUNT=0; the write wins.
- Width rules: launch_slot zero-extended to 3 bits. Unused readdata bits read 0.

Decomposition:
- Shared package bullet_pkg holds:
  - register address constants (REG_SLOTS=0, REG_LIFETIME=1, REG_CTRL=2, REG_COUNT=3);
  - CTRL bit positions;
  - MAX_SLOTS=8;
  - the lifetime counter width (8).
- One natural sub-module, bullet_slot_timer, instantiated NUM_SLOTS times. It holds one slot's enable and lifetime counter, with inputs load, retire, frame_tick and reload, and outputs en and expire.
- Allocation priority encoder, cooldown and Avalon decode stay in the top level.

Test Plan:
- Reset, then a fire edge -> launch pulse 1 cycle later, launch_slot=0, slot_en=0001, COUNT=1, cooldown=8.
- Fire edge held with autofire=0, then 8 frame_ticks, then a new edge -> exactly 2 launches, slots 0 and 1, slot_en=0011. A second edge issued before cooldown expires is dropped.
- Lifetime reload=3, launch, then 3 frame_ticks -> slot_en[0] clears on the 3rd tick. hit[1] pulse on slot 1 -> slot_en[1] clears the next cycle.
- All 4 slots full, fire -> no launch. hit[2] and a fire edge in the same cycle -> no launch that cycle. Fire edge the next cycle (cooldown 0) -> launch_slot=2.
- Write CTRL=0 with slots active -> slot_en=0 and fire ignored. Write SLOTS=0b0101 with enable=1 and slot_en=1111 -> slot_en=1010.
- COUNT at 0xFFFF plus a launch -> wraps to 0. A write to COUNT concurrent with a launch -> reads 0. Assert reset mid-cooldown -> all outputs 0 and lifetime reads 60.

Source files
------------

// File: rtl/bullet_pkg.sv
// Shared constants for the bullet slot scheduler: register map, CTRL bits, sizes.
package bullet_pkg;

  localparam int unsigned MAX_SLOTS = 8;
  localparam int unsigned LIFE_W    = 8;

  typedef enum logic [1:0] {
    REG_SLOTS    = 2'd0,
    REG_LIFETIME = 2'd1,
    REG_CTRL     = 2'd2,
    REG_COUNT    = 2'd3
  } reg_addr_e;

  localparam int unsigned CTRL_ENABLE_BIT   = 0;
  localparam int unsigned CTRL_AUTOFIRE_BIT = 1;

endpackage

// File: rtl/bullet_slot_timer.sv
// One bullet slot: enable flag plus frame-based lifetime countdown.
module bullet_slot_timer
  import bullet_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              retire,
  input  logic              frame_tick,
  input  logic [LIFE_W-1:0] reload,
  output logic              en,
  output logic              expire
);

  logic [LIFE_W-1:0] life;

  assign expire = en & frame_tick & (life == LIFE_W'(1));

  // Load only targets a free slot, so it outranks retire causes on that slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en   <= 1'b0;
      life <= '0;
    end else if (load) begin
      en   <= 1'b1;
      life <= reload;
    end else if (en && retire) begin
      en   <= 1'b0;
      life <= '0;
    end else if (en && frame_tick) begin
      life <= life - LIFE_W'(1);
    end
  end

endmodule

// File: rtl/bullet_slot_scheduler.sv
// Allocates bullet slots on fire requests (lowest free slot, cooldown-gated) and
// retires them on hit, off-screen, lifetime expiry or software clear.
module bullet_slot_scheduler
  import bullet_pkg::*;
#(
  parameter int unsigned NUM_SLOTS       = 4,
  parameter int unsigned LIFETIME_FRAMES = 60,
  parameter int unsigned COOLDOWN_FRAMES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fire,
  input  logic                 frame_tick,
  input  logic [NUM_SLOTS-1:0] hit,
  input  logic [NUM_SLOTS-1:0] offscreen,
  output logic [NUM_SLOTS-1:0] slot_en,
  output logic                 launch,
  output logic [2:0]           launch_slot,
  input  logic [1:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata
);

  logic                 fire_q;
  logic [7:0]           cooldown;
  logic [LIFE_W-1:0]    lifetime_reload;
  logic                 ctrl_enable;
  logic                 ctrl_autofire;
  logic [15:0]          launch_count;

  reg_addr_e            addr_e;
  logic                 wr_en;
  logic                 wr_slots, wr_life, wr_ctrl, wr_count;
  logic                 disable_wr;
  logic                 request;
  logic                 have_free;
  logic [2:0]           free_idx;
  logic                 launch_go;
  logic [NUM_SLOTS-1:0] load_vec;
  logic [NUM_SLOTS-1:0] retire_vec;
  logic [NUM_SLOTS-1:0] expire_vec;

  assign addr_e     = reg_addr_e'(address);
  assign wr_en      = chipselect & ~write_n;
  assign wr_slots   = wr_en & (addr_e == REG_SLOTS);
  assign wr_life    = wr_en & (addr_e == REG_LIFETIME);
  assign wr_ctrl    = wr_en & (addr_e == REG_CTRL);
  assign wr_count   = wr_en & (addr_e == REG_COUNT);
  assign disable_wr = wr_ctrl & ~writedata[CTRL_ENABLE_BIT];

  assign request = ctrl_autofire ? fire : (fire & ~fire_q);

  always_comb begin
    have_free = 1'b0;
    free_idx  = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!slot_en[i] && !have_free) begin
        have_free = 1'b1;
        free_idx  = 3'(i);
      end
    end
  end

  // Freeness comes from registered slot_en, so a slot retiring this cycle is not a candidate.
  assign launch_go = request & ctrl_enable & ~disable_wr & (cooldown == '0) & have_free;

  always_comb begin
    load_vec = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      load_vec[i] = launch_go && (free_idx == 3'(i));
    end
  end

  assign retire_vec = hit | offscreen | expire_vec
                    | (wr_slots ? writedata[NUM_SLOTS-1:0] : '0)
                    | {NUM_SLOTS{disable_wr}};

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    bullet_slot_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (load_vec[g]),
      .retire     (retire_vec[g]),
      .frame_tick (frame_tick),
      .reload     (lifetime_reload),
      .en         (slot_en[g]),
      .expire     (expire_vec[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fire_q          <= 1'b0;
      cooldown        <= '0;
      lifetime_reload <= LIFE_W'(LIFETIME_FRAMES);
      ctrl_enable     <= 1'b1;
      ctrl_autofire   <= 1'b0;
      launch_count    <= '0;
      launch          <= 1'b0;
      launch_slot     <= '0;
    end else begin
      fire_q <= fire;
      launch <= launch_go;
      if (launch_go) begin
        launch_slot <= free_idx;
        cooldown    <= 8'(COOLDOWN_FRAMES);
      end else if (frame_tick && cooldown != '0) begin
        cooldown <= cooldown - 8'd1;
      end
      if (wr_life) begin
        lifetime_reload <= (writedata[LIFE_W-1:0] == '0) ? LIFE_W'(1) : writedata[LIFE_W-1:0];
      end
      if (wr_ctrl) begin
        ctrl_enable   <= writedata[CTRL_ENABLE_BIT];
        ctrl_autofire <= writedata[CTRL_AUTOFIRE_BIT];
      end
      if (wr_count) begin
        launch_count <= '0;
      end else if (launch_go) begin
        launch_count <= launch_count + 16'd1;
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (addr_e)
      REG_SLOTS:    readdata[NUM_SLOTS-1:0] = slot_en;
      REG_LIFETIME: readdata[LIFE_W-1:0]    = lifetime_reload;
      REG_CTRL:     readdata[1:0]           = {ctrl_autofire, ctrl_enable};
      REG_COUNT:    readdata[15:0]          = launch_count;
      default:      readdata                = '0;
    endcase
  end

endmodule
